// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-RAM loader.
// The instruction RAM uses RAM_SIZE and RAM_ADDR_WIDTH from here as well.
package imem_pkg;
  localparam int          RAM_SIZE        = 512;
  localparam int          RAM_ADDR_WIDTH  = 9;
  localparam logic [31:0] TEXT_BASE       = 32'h0040_0000;
  localparam logic [7:0]  START_BYTE      = 8'hA5;
  localparam int          TIMEOUT_DEFAULT = 1000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } state_t;

  // Byte offset of a fetch address from the start of the text segment.
  function automatic logic [31:0] text_offset(input logic [31:0] pc);
    return pc - TEXT_BASE;
  endfunction
endpackage

// File: rtl/imem_frame_rx.sv
// Byte-to-word assembler for the load frame: MSB-first word packing,
// running XOR checksum, word counter and inter-byte idle timer.
module imem_frame_rx
  import imem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      frame_start,
  input  logic                      data_en,
  input  logic                      timer_en,
  input  logic                      take,
  input  logic [7:0]                rx_data,
  output logic                      we,
  output logic [RAM_ADDR_WIDTH-1:0] waddr,
  output logic [31:0]               wdata,
  output logic [RAM_ADDR_WIDTH:0]   wcount,
  output logic [7:0]                chk,
  output logic                      timed_out
);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [1:0]    byte_idx;
  logic [23:0]   shift;
  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      wcount   <= '0;
      chk      <= '0;
      byte_idx <= '0;
      shift    <= '0;
    end else begin
      we <= 1'b0;
      if (we) wcount <= wcount + 1'b1;
      if (frame_start) begin
        wcount   <= '0;
        chk      <= '0;
        byte_idx <= '0;
        shift    <= '0;
      end else if (data_en && take) begin
        shift    <= {shift[15:0], rx_data};
        byte_idx <= byte_idx + 1'b1;
        chk      <= chk ^ rx_data;
        // Fourth byte completes the word; the write happens on the next cycle.
        if (byte_idx == 2'd3) begin
          we    <= 1'b1;
          waddr <= wcount[RAM_ADDR_WIDTH-1:0];
          wdata <= {shift, rx_data};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !timer_en || take) idle_cnt <= '0;
    else                               idle_cnt <= idle_cnt + 1'b1;
  end

  assign timed_out = timer_en && !take && (idle_cnt == IW'(TIMEOUT - 1));
endmodule

// File: rtl/imem_loader.sv
// Boot loader for the instruction RAM: receives a framed byte stream, writes
// the RAM while holding the CPU, then gives the RAM read port to instruction fetch.
//
// state | meaning
// IDLE  | after reset, waiting for START_BYTE
// LEN0  | expecting low byte of word count
// LEN1  | expecting high byte of word count
// DATA  | receiving word bytes, writing RAM
// CHK   | expecting XOR checksum byte
// RUN   | CPU released, RAM read port serves fetch
// ERR   | bad frame, CPU held, waiting for START_BYTE
module imem_loader
  import imem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  output logic                      cpu_hold,
  input  logic [31:0]               cpu_pc,
  output logic [31:0]               cpu_inst,
  output logic                      mem_we,
  output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  output logic                      load_err
);
  state_t                    state, state_nxt;
  logic [15:0]               len;
  logic [15:0]               len_in;
  logic [RAM_ADDR_WIDTH:0]   len_valid;
  logic [RAM_ADDR_WIDTH-1:0] waddr;
  logic [RAM_ADDR_WIDTH:0]   wcount;
  logic [7:0]                chk;
  logic [31:0]               pc_off;
  logic                      take, is_start, frame_start, timer_en, timed_out;

  assign rx_ready    = !mem_we;
  assign take        = rx_valid && rx_ready;
  assign is_start    = take && (rx_data == START_BYTE);
  assign frame_start = is_start && (state inside {ST_IDLE, ST_RUN, ST_ERR});
  assign timer_en    = state inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CHK};
  assign len_in      = {rx_data, len[7:0]};
  assign pc_off      = text_offset(cpu_pc);

  imem_frame_rx #(.TIMEOUT(TIMEOUT)) u_frame_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .data_en     (state == ST_DATA),
    .timer_en    (timer_en),
    .take        (take),
    .rx_data     (rx_data),
    .we          (mem_we),
    .waddr       (waddr),
    .wdata       (mem_wdata),
    .wcount      (wcount),
    .chk         (chk),
    .timed_out   (timed_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_RUN, ST_ERR: if (is_start) state_nxt = ST_LEN0;
      ST_LEN0: if (take) state_nxt = ST_LEN1;
      ST_LEN1: if (take) begin
        if (len_in > 16'(RAM_SIZE)) state_nxt = ST_ERR;
        else if (len_in == '0)      state_nxt = ST_CHK;
        else                        state_nxt = ST_DATA;
      end
      ST_DATA: if (mem_we && (16'(wcount) + 16'd1 == len)) state_nxt = ST_CHK;
      ST_CHK:  if (take) state_nxt = (rx_data == chk) ? ST_RUN : ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
    if (timed_out) state_nxt = ST_ERR;
  end

  // The fetchable length only changes on a successful checksum.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len       <= '0;
      len_valid <= '0;
    end else begin
      if (state == ST_LEN0 && take) len[7:0]  <= rx_data;
      if (state == ST_LEN1 && take) len[15:8] <= rx_data;
      if (state == ST_CHK && state_nxt == ST_RUN) len_valid <= len[RAM_ADDR_WIDTH:0];
    end
  end

  always_comb begin
    cpu_hold = (state != ST_RUN) || is_start;
    load_err = (state == ST_ERR);
    mem_addr = waddr;
    cpu_inst = '0;
    if (state == ST_RUN) begin
      mem_addr = cpu_pc[RAM_ADDR_WIDTH+1:2];
      if (pc_off < 32'(4 * RAM_SIZE) &&
          {1'b0, pc_off[RAM_ADDR_WIDTH+1:2]} < len_valid)
        cpu_inst = mem_rdata;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames, a fetch-address table,
// and randomized frames checked against an address-arithmetic fetch model.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset_n, rx_valid, rx_ready, cpu_hold, mem_we, load_err;
  logic [7:0]  rx_data;
  logic [31:0] cpu_pc, cpu_inst, mem_wdata, mem_rdata;
  logic [8:0]  mem_addr;

  logic [31:0] ram [RAM_SIZE];
  logic        ram_loaded = 1'b0;
  logic [31:0] tx_words  [RAM_SIZE];
  logic [31:0] mdl_words [RAM_SIZE];
  int          mdl_len = 0;
  bit          mdl_run = 1'b0;
  logic [40:0] exp_wq [$];
  logic [40:0] wq_e;
  int          n_cmp = 0, n_bad = 0, we_cnt = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  imem_loader #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .cpu_hold  (cpu_hold),
    .cpu_pc    (cpu_pc),
    .cpu_inst  (cpu_inst),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .load_err  (load_err)
  );

  // RAM starts with recognisable junk so unguarded reads show up as nonzero.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < RAM_SIZE; i++) ram[i] <= 32'hBAD0_0000 | 32'(i);
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      if (exp_wq.size() == 0) begin
        check("write_unexpected_addr", {23'b0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wq_e = exp_wq.pop_front();
        check("write_addr", {23'b0, mem_addr}, {23'b0, wq_e[40:32]});
        check("write_data", mem_wdata, wq_e[31:0]);
      end
      check("rx_ready_in_write", {31'b0, rx_ready}, 32'd0);
    end
  end

  function automatic logic [31:0] ref_inst(input logic [31:0] pc);
    longint off;
    off = {32'b0, pc} - {32'b0, TEXT_BASE};
    if (!mdl_run || off < 0 || off >= 4 * RAM_SIZE) return 32'h0;
    if (off / 4 >= mdl_len) return 32'h0;
    return mdl_words[off / 4];
  endfunction

  // All tasks start and end one time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (rx_ready) done = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    if (!done) check("rx_ready_stuck_low", 32'd0, 32'd1);
  endtask

  // Sends a frame of tx_words[0..len-1]; chk_xor != 0 corrupts the checksum.
  task automatic send_frame(input int len, input logic [7:0] chk_xor, output bit ok);
    logic [7:0] chk;
    chk = 8'h00;
    send_byte(START_BYTE);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int i = 0; i < len; i++) begin
      exp_wq.push_back({9'(i), tx_words[i]});
      for (int b = 3; b >= 0; b--) begin
        send_byte(tx_words[i][8*b +: 8]);
        chk ^= tx_words[i][8*b +: 8];
      end
    end
    ok = (chk_xor == 8'h00);
    send_byte(chk ^ chk_xor);
    if (ok) begin
      mdl_len = len;
      for (int i = 0; i < len; i++) mdl_words[i] = tx_words[i];
    end
    mdl_run = ok;
  endtask

  task automatic expect_outcome(input string tag, input bit ok);
    check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, !ok});
    check({tag, "_load_err"}, {31'b0, load_err}, {31'b0, !ok});
  endtask

  task automatic probe_pc(input string name, input logic [31:0] pc);
    cpu_pc = pc;
    #1;
    check(name, cpu_inst, ref_inst(pc));
    tick();
  endtask

  task automatic random_probes(input string tag, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0:       pc = TEXT_BASE + 4 * $urandom_range(0, mdl_len + 2);
        1:       pc = TEXT_BASE + $urandom_range(0, 4 * RAM_SIZE + 7) - 4;
        default: pc = $urandom;
      endcase
      probe_pc($sformatf("%s_pc_%h", tag, pc), pc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, wc, len;

    vecs[0] = '{32'h0040_0000, 32'h2410_0000};
    vecs[1] = '{32'h0040_0004, 32'h2411_0000};
    vecs[2] = '{32'h0040_0008, 32'h0000_0000};
    vecs[3] = '{32'h0040_0002, 32'h2410_0000};
    vecs[4] = '{32'h003F_FFFC, 32'h0000_0000};
    vecs[5] = '{32'h0040_0800, 32'h0000_0000};
    vecs[6] = '{32'h0040_07FC, 32'h0000_0000};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000};

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cpu_pc   = TEXT_BASE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_hold",  {31'b0, cpu_hold}, 32'd1);
    check("rst_rx_ready",  {31'b0, rx_ready}, 32'd1);
    check("rst_mem_we",    {31'b0, mem_we},   32'd0);
    check("rst_cpu_inst",  cpu_inst,          32'd0);
    check("rst_load_err",  {31'b0, load_err}, 32'd0);
    check("rst_mem_addr",  {23'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata,         32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Two-word frame; XOR of its word bytes is 0x01.
    tx_words[0] = 32'h2410_0000;
    tx_words[1] = 32'h2411_0000;
    send_frame(2, 8'h00, ok);
    expect_outcome("frame2", 1'b1);
    for (int i = 0; i < 8; i++) begin
      cpu_pc = vecs[i].pc;
      #1;
      check($sformatf("vec%0d_pc_%h", i, vecs[i].pc), cpu_inst, vecs[i].inst);
      tick();
    end

    send_byte(8'h00);
    check("run_ignore_byte_hold", {31'b0, cpu_hold}, 32'd0);
    rx_data  = START_BYTE;
    rx_valid = 1'b1;
    @(negedge clk);
    check("start_in_run_hold", {31'b0, cpu_hold}, 32'd1);
    tick();
    rx_valid = 1'b0;
    mdl_run  = 1'b0;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    expect_outcome("len0", 1'b1);
    mdl_run = 1'b1;
    mdl_len = 0;
    probe_pc("len0_pc0", TEXT_BASE);
    probe_pc("len0_pc4", TEXT_BASE + 4);
    random_probes("len0", 4);

    // Same two words with checksum byte 0x12 instead of 0x01.
    send_frame(2, 8'h13, ok);
    expect_outcome("badchk", 1'b0);
    probe_pc("badchk_pc0", TEXT_BASE);

    for (int i = 0; i < 3; i++) tx_words[i] = $urandom;
    send_frame(3, 8'h00, ok);
    expect_outcome("recover", 1'b1);
    for (int i = 0; i < 4; i++) probe_pc($sformatf("recover_w%0d", i), TEXT_BASE + 4 * i);

    wc = we_cnt;
    mdl_run = 1'b0;
    send_byte(START_BYTE);
    send_byte(8'h01);
    send_byte(8'h02);
    expect_outcome("len513", 1'b0);
    repeat (3) tick();
    check("len513_no_write", we_cnt, wc);

    send_byte(START_BYTE);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    n = 0;
    while (!load_err && n < 3 * TMO) begin
      tick();
      n++;
    end
    check("timeout_load_err", {31'b0, load_err}, 32'd1);
    n_cmp++;
    if (n < TMO - 1 || n > TMO + 1) begin
      n_bad++;
      $display("FAIL timeout_cycles: got %0d expected %0d", n, TMO);
    end

    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) tx_words[i] = $urandom;
      send_frame(len, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, ok);
      expect_outcome($sformatf("rand%0d", f), ok);
      random_probes($sformatf("rand%0d", f), 8);
    end

    for (int i = 0; i < RAM_SIZE; i++) tx_words[i] = $urandom;
    send_frame(RAM_SIZE, 8'h00, ok);
    expect_outcome("full", 1'b1);
    probe_pc("full_first", TEXT_BASE);
    probe_pc("full_last",  TEXT_BASE + 4 * (RAM_SIZE - 1));
    probe_pc("full_above", TEXT_BASE + 4 * RAM_SIZE);
    probe_pc("full_below", TEXT_BASE - 4);
    random_probes("full", 6);

    send_byte(START_BYTE);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    reset_n = 1'b0;
    mdl_run = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("midrst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check("midrst_rx_ready", {31'b0, rx_ready}, 32'd1);
    check("midrst_load_err", {31'b0, load_err}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    probe_pc("midrst_pc0", TEXT_BASE);
    repeat (2) tick();
    check("pending_writes", exp_wq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
